// File: rtl/ram_arbiter_pkg.sv
// Shared types for the fetch/memory-stage arbitration onto the one-port data RAM.
//   Word, RamAddress  : data word and byte address types
//   WORD_ADDRESS_SIZE : byte-offset bits inside a word (alignment check)
//   ArbState          : arbiter priority mode
package ram_arbiter_pkg;

  localparam int unsigned WORD_W            = 32;
  localparam int unsigned ADDR_W            = 16;
  localparam int unsigned WORD_ADDRESS_SIZE = 2;
  localparam int unsigned STARVE_W          = 4;

  typedef logic [WORD_W-1:0] Word;
  typedef logic [ADDR_W-1:0] RamAddress;

  typedef enum logic {ARB_NORMAL, ARB_BOOST} ArbState;

  // Word-aligned iff the byte-offset bits are all zero.
  function automatic logic is_aligned(input RamAddress addr);
    return addr[WORD_ADDRESS_SIZE-1:0] == '0;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data RAM.
//   fetch port : i_req/i_addr in, i_ready/i_rvalid/i_rdata/i_err out
//   data port  : d_req/d_we/d_addr/d_wdata in, d_ready/d_rvalid/d_rdata/d_err out
//   RAM port   : ram_we/ram_address/ram_in out, ram_out in
// slave = arbiter side, master = requester/RAM side.
interface ram_arbiter_if;
  import ram_arbiter_pkg::*;

  logic      i_req;
  RamAddress i_addr;
  logic      i_ready;
  logic      i_rvalid;
  Word       i_rdata;
  logic      i_err;

  logic      d_req;
  logic      d_we;
  RamAddress d_addr;
  Word       d_wdata;
  logic      d_ready;
  logic      d_rvalid;
  Word       d_rdata;
  logic      d_err;

  logic      ram_we;
  RamAddress ram_address;
  Word       ram_in;
  Word       ram_out;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_out,
    output i_ready, i_rvalid, i_rdata, i_err,
    output d_ready, d_rvalid, d_rdata, d_err,
    output ram_we, ram_address, ram_in
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_out,
    input  i_ready, i_rvalid, i_rdata, i_err,
    input  d_ready, d_rvalid, d_rdata, d_err,
    input  ram_we, ram_address, ram_in
  );

endinterface

// File: rtl/ram_resp_reg.sv
// One-cycle response register for a single requester port.
//   clk, reset : clock, async active-low reset
//   grant_i    : port was granted this cycle
//   err_i      : granted address is misaligned
//   rdata_i    : RAM read word in the grant cycle
//   rvalid_o, err_o, rdata_o : registered response (rdata holds when idle)
module ram_resp_reg
  import ram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic grant_i,
  input  logic err_i,
  input  Word  rdata_i,
  output logic rvalid_o,
  output logic err_o,
  output Word  rdata_o
);

  logic rvalid_q, rvalid_d;
  logic err_q, err_d;
  Word  rdata_q, rdata_d;

  // Next response; a misaligned access returns zero data.
  always_comb begin
    rvalid_d = grant_i;
    err_d    = grant_i & err_i;
    rdata_d  = rdata_q;
    if (grant_i) begin
      rdata_d = err_i ? '0 : rdata_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter sharing the one-port data RAM between instruction fetch and the
// memory stage. Data port wins by default; after STARVE_LIMIT consecutive
// fetch denials the fetch port is boosted until it is served.
//   STARVE_LIMIT : denied fetch cycles before boost (1..15)
//   clk, reset   : clock, async active-low reset
//   bus          : requester ports and RAM port (slave side)
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  ArbState             state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                gnt_i, gnt_d;

  // State and starve counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Next state: boost once the counter reaches the limit, leave once fetch is
  // served or withdraws.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (!bus.i_req || gnt_i) begin
      starve_d = '0;
    end else if (starve_q < LIMIT) begin
      starve_d = starve_q + STARVE_W'(1);
    end
    case (state_q)
      ARB_NORMAL: if (starve_d == LIMIT) state_d = ARB_BOOST;
      ARB_BOOST:  if (gnt_i || !bus.i_req) state_d = ARB_NORMAL;
      default:    state_d = ARB_NORMAL;
    endcase
  end

  // Outputs: grant selection and RAM port drive. Grants are held off while
  // reset is asserted so every output reads zero immediately.
  always_comb begin
    gnt_i           = 1'b0;
    gnt_d           = 1'b0;
    bus.ram_we      = 1'b0;
    bus.ram_address = '0;
    bus.ram_in      = '0;
    if (reset) begin
      if (state_q == ARB_BOOST) begin
        gnt_i = bus.i_req;
        gnt_d = bus.d_req & ~bus.i_req;
      end else begin
        gnt_d = bus.d_req;
        gnt_i = bus.i_req & ~bus.d_req;
      end
    end
    if (gnt_d) begin
      bus.ram_address = bus.d_addr;
      if (bus.d_we && is_aligned(bus.d_addr)) begin
        bus.ram_we = 1'b1;
        bus.ram_in = bus.d_wdata;
      end
    end else if (gnt_i) begin
      bus.ram_address = bus.i_addr;
    end
  end

  assign bus.i_ready = gnt_i;
  assign bus.d_ready = gnt_d;

  // Writes also return the pre-write word, since the RAM updates on the same edge.
  ram_resp_reg u_i_resp (
    .clk      (clk),
    .reset    (reset),
    .grant_i  (gnt_i),
    .err_i    (~is_aligned(bus.i_addr)),
    .rdata_i  (bus.ram_out),
    .rvalid_o (bus.i_rvalid),
    .err_o    (bus.i_err),
    .rdata_o  (bus.i_rdata)
  );

  ram_resp_reg u_d_resp (
    .clk      (clk),
    .reset    (reset),
    .grant_i  (gnt_d),
    .err_i    (~is_aligned(bus.d_addr)),
    .rdata_i  (bus.ram_out),
    .rvalid_o (bus.d_rvalid),
    .err_o    (bus.d_err),
    .rdata_o  (bus.d_rdata)
  );

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios then random traffic, every cycle
// compared against a behavioural model (denial streak + shadow memory).
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_arbiter_if bus ();

  ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM environment: combinational read, write on the clock edge.
  Word mem [0:255];
  assign bus.ram_out = mem[bus.ram_address[9:2]];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_address[9:2]] <= bus.ram_in;
  end

  // Model state.
  Word  ref_mem [0:255];
  int   denied;
  logic e_irv, e_ierr, e_drv, e_derr;
  Word  e_ird, e_drd;
  logic g_i, g_d;
  int   nvec, nerr;

  // Staged stimulus, applied on the falling edge.
  logic      s_rst, s_ireq, s_dreq, s_dwe;
  RamAddress s_iaddr, s_daddr;
  Word       s_dwdata;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input Word obs, input Word exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_irv = 1'b0; e_ierr = 1'b0; e_ird = '0;
    e_drv = 1'b0; e_derr = 1'b0; e_drd = '0;
    denied = 0;
  endtask

  task automatic tick();
    logic      ew;
    RamAddress ea;
    Word       ein;
    @(negedge clk);
    reset      = s_rst;
    bus.i_req  = s_ireq;
    bus.i_addr = s_iaddr;
    bus.d_req  = s_dreq;
    bus.d_we   = s_dwe;
    bus.d_addr = s_daddr;
    bus.d_wdata = s_dwdata;
    #1;
    chk1("i_rvalid", bus.i_rvalid, e_irv);
    chk1("i_err", bus.i_err, e_ierr);
    chkw("i_rdata", bus.i_rdata, e_ird);
    chk1("d_rvalid", bus.d_rvalid, e_drv);
    chk1("d_err", bus.d_err, e_derr);
    chkw("d_rdata", bus.d_rdata, e_drd);
    // Data first, unless fetch has already been denied LIMIT times in a row.
    g_i = s_rst && s_ireq && (!s_dreq || denied >= int'(LIMIT));
    g_d = s_rst && s_dreq && !g_i;
    ew  = g_d && s_dwe && (s_daddr[1:0] == 2'b00);
    ea  = g_d ? s_daddr : (g_i ? s_iaddr : '0);
    ein = ew ? s_dwdata : '0;
    chk1("i_ready", bus.i_ready, g_i);
    chk1("d_ready", bus.d_ready, g_d);
    chk1("ram_we", bus.ram_we, ew);
    chkw("ram_address", Word'(bus.ram_address), Word'(ea));
    chkw("ram_in", bus.ram_in, ein);
    if (bus.i_ready) $display("TRACE %0t grant fetch addr=%h", $time, bus.i_addr);
    if (bus.d_ready) $display("TRACE %0t grant data we=%b addr=%h", $time, bus.d_we, bus.d_addr);
    if (!s_rst) begin
      model_reset();
    end else begin
      e_irv  = g_i;
      e_ierr = g_i && (s_iaddr[1:0] != 2'b00);
      if (g_i) e_ird = e_ierr ? '0 : ref_mem[s_iaddr[9:2]];
      e_drv  = g_d;
      e_derr = g_d && (s_daddr[1:0] != 2'b00);
      if (g_d) e_drd = e_derr ? '0 : ref_mem[s_daddr[9:2]];
      if (ew) ref_mem[s_daddr[9:2]] = s_dwdata;
      denied = (s_ireq && !g_i) ? denied + 1 : 0;
    end
  endtask

  task automatic set_d(input logic req, input logic we, input RamAddress a, input Word w);
    s_dreq = req; s_dwe = we; s_daddr = a; s_dwdata = w;
  endtask

  task automatic set_i(input logic req, input RamAddress a);
    s_ireq = req; s_iaddr = a;
  endtask

  function automatic RamAddress rand_addr();
    RamAddress a;
    a = RamAddress'($urandom_range(0, 255) * 4);
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    int unsigned dpct;
    nvec = 0;
    nerr = 0;
    for (int k = 0; k < 256; k++) begin
      mem[k]     = '0;
      ref_mem[k] = '0;
    end
    model_reset();
    g_i = 1'b0; g_d = 1'b0;
    s_rst = 1'b0;
    set_i(1'b0, '0);
    set_d(1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    // Held in reset, then released.
    tick();
    tick();
    s_rst = 1'b1;
    tick();

    // Read after write at 0x10.
    set_d(1'b1, 1'b1, 16'h0010, 32'd42); tick();
    set_d(1'b1, 1'b0, 16'h0010, '0);     tick();
    set_d(1'b0, 1'b0, '0, '0);           tick();

    // Contention, both requests held.
    set_i(1'b1, 16'h0020);
    set_d(1'b1, 1'b0, 16'h0010, '0);
    for (int c = 0; c < 6; c++) tick();
    set_i(1'b0, '0);
    set_d(1'b0, 1'b0, '0, '0);
    tick();

    // Seed words, then fetch three consecutive words.
    set_d(1'b1, 1'b1, 16'h0000, 32'd11); tick();
    set_d(1'b1, 1'b1, 16'h0004, 32'd22); tick();
    set_d(1'b1, 1'b1, 16'h0008, 32'd33); tick();
    set_d(1'b0, 1'b0, '0, '0);
    set_i(1'b1, 16'h0000); tick();
    set_i(1'b1, 16'h0004); tick();
    set_i(1'b1, 16'h0008); tick();
    set_i(1'b0, '0);       tick();

    // Misaligned write must not disturb the word at 0x4.
    set_d(1'b1, 1'b1, 16'h0006, 32'd7); tick();
    set_d(1'b1, 1'b0, 16'h0004, '0);    tick();
    set_d(1'b0, 1'b0, '0, '0);          tick();

    // Reset between grant and response edge.
    set_d(1'b1, 1'b0, 16'h0010, '0); tick();
    #2;
    reset = 1'b0;
    s_rst = 1'b0;
    #1;
    chk1("rst_d_ready", bus.d_ready, 1'b0);
    chk1("rst_ram_we", bus.ram_we, 1'b0);
    chkw("rst_ram_address", Word'(bus.ram_address), '0);
    chkw("rst_d_rdata", bus.d_rdata, '0);
    chkw("rst_i_rdata", bus.i_rdata, '0);
    model_reset();
    set_d(1'b0, 1'b0, '0, '0);
    tick();
    s_rst = 1'b1;
    set_i(1'b1, 16'h0000);
    set_d(1'b1, 1'b0, 16'h0010, '0);
    tick();
    set_i(1'b0, '0);
    set_d(1'b0, 1'b0, '0, '0);
    tick();

    // Idle.
    for (int c = 0; c < 10; c++) tick();

    // Random traffic; second half keeps the data port busy to force boosts.
    for (int n = 0; n < 400; n++) begin
      dpct = (n < 200) ? 32'd50 : 32'd90;
      if (!s_ireq || g_i) begin
        s_ireq  = ($urandom_range(0, 99) < 60);
        s_iaddr = rand_addr();
      end
      if (!s_dreq || g_d) begin
        s_dreq   = ($urandom_range(0, 99) < dpct);
        s_dwe    = 1'($urandom_range(0, 1));
        s_daddr  = rand_addr();
        s_dwdata = $urandom;
      end
      tick();
    end
    set_i(1'b0, '0);
    set_d(1'b0, 1'b0, '0, '0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
